// File: rtl/window_gen_3x3.sv
// window_gen_3x3
// Builds a sliding 3x3 window from a raster-order pixel stream using two
// line buffers. Only fully-inside windows are emitted: (IMG_W-2) x (IMG_H-2)
// per frame, no padding. Window slot order matches the MAC stage's in0..in8:
// win0..win2 = top row, win3..win5 = middle row, win6..win8 = bottom row,
// each row left to right. win8 is the most recently accepted pixel.

module window_gen_3x3 #(
    parameter int n     = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] pix_in,
    input  logic         pix_valid,
    output logic         pix_ready,
    output logic [n-1:0] win0,
    output logic [n-1:0] win1,
    output logic [n-1:0] win2,
    output logic [n-1:0] win3,
    output logic [n-1:0] win4,
    output logic [n-1:0] win5,
    output logic [n-1:0] win6,
    output logic [n-1:0] win7,
    output logic [n-1:0] win8,
    output logic         win_valid,
    input  logic         win_ready,
    output logic         frame_last
);

    // Counter widths, never narrower than one bit.
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Raster position of the next pixel to be accepted.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Line buffers: lb_mid holds the previous row, lb_top the one before it.
    logic [n-1:0] lb_top [IMG_W];
    logic [n-1:0] lb_mid [IMG_W];

    // Window register, indexed in output slot order (0..8).
    logic [n-1:0] win_r [9];

    logic         accept;
    logic         col_at_last;
    logic         row_at_last;
    logic         qualify;
    logic         at_frame_end;
    logic [n-1:0] top_rd;
    logic [n-1:0] mid_rd;

    // The only stall source is a presented window that downstream refuses.
    assign pix_ready    = !win_valid || win_ready;
    assign accept       = pix_valid && pix_ready;

    assign col_at_last  = (col == COL_LAST);
    assign row_at_last  = (row == ROW_LAST);
    assign qualify      = (row >= ROW_TWO) && (col >= COL_TWO);
    assign at_frame_end = row_at_last && col_at_last;

    // Pre-update line buffer contents at the current column.
    assign top_rd = lb_top[col];
    assign mid_rd = lb_mid[col];

    // Advance the raster position on every accepted pixel; wrap at frame end.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_at_last) begin
                col <= '0;
                row <= row_at_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Roll the column of line buffers down by one row on each accept.
    // NOTE: line buffers are deliberately not reset; rows 0-1 of every frame
    // overwrite each entry before it feeds an emitted window, and leaving
    // them reset-free lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[col] <= mid_rd;
            lb_mid[col] <= pix_in;
        end
    end

    // Shift the window left and insert the new {top, middle, bottom} column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= '0;
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_r[3*r]     <= win_r[3*r + 1];
                win_r[3*r + 1] <= win_r[3*r + 2];
            end
            win_r[2] <= top_rd;
            win_r[5] <= mid_rd;
            win_r[8] <= pix_in;
        end
    end

    // Flag a window one cycle after a qualifying accept; hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid  <= 1'b0;
            frame_last <= 1'b0;
        end else if (accept) begin
            win_valid  <= qualify;
            frame_last <= qualify && at_frame_end;
        end else if (win_ready) begin
            win_valid  <= 1'b0;
            frame_last <= 1'b0;
        end
    end

    assign win0 = win_r[0];
    assign win1 = win_r[1];
    assign win2 = win_r[2];
    assign win3 = win_r[3];
    assign win4 = win_r[4];
    assign win5 = win_r[5];
    assign win6 = win_r[6];
    assign win7 = win_r[7];
    assign win8 = win_r[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3
// Directed scenarios on a 5x4 image with randomized handshake gaps. A
// reference model stores the received image in a 2D array and derives each
// expected window directly from pixel coordinates; a golden list of the six
// windows of the canonical frame is built from the pixel formula r*5+c+1.

module tb_window_gen_3x3;

    localparam int N = 8;
    localparam int W = 5;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [N-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic         win_valid;
    logic         win_ready;
    logic         frame_last;

    window_gen_3x3 #(.n(N), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win0      (win0),
        .win1      (win1),
        .win2      (win2),
        .win3      (win3),
        .win4      (win4),
        .win5      (win5),
        .win6      (win6),
        .win7      (win7),
        .win8      (win8),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .frame_last(frame_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0][N-1:0] w;
        logic              last;
    } win_t;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [N-1:0] img [H][W];
    int           m_row, m_col;
    logic         m_valid;
    win_t         m_win;
    bit           stall_req;

    win_t golden[$];
    win_t got_q[$];

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0][N-1:0] dut_win();
        return {win8, win7, win6, win5, win4, win3, win2, win1, win0};
    endfunction

    task automatic model_reset();
        m_row   = 0;
        m_col   = 0;
        m_valid = 1'b0;
        m_win   = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_frame_last", frame_last, 1'b0);
        check("rst_window", dut_win(), '0);
        check("rst_pix_ready", pix_ready, 1'b1);
    endtask

    // One clock cycle: drive at negedge, check, predict, wait for next negedge.
    task automatic cycle(input logic v, input logic [N-1:0] p, input logic wr, output logic acc);
        win_t g;
        pix_valid = v;
        pix_in    = p;
        win_ready = wr;
        #1;
        check("pix_ready", pix_ready, !m_valid || wr);
        check("win_valid", win_valid, m_valid);
        if (m_valid) begin
            check("window", dut_win(), m_win.w);
            check("frame_last", frame_last, m_win.last);
        end
        if (win_valid && wr) begin
            g.w    = dut_win();
            g.last = frame_last;
            got_q.push_back(g);
        end
        acc = v && (!m_valid || wr);
        if (acc) begin
            img[m_row][m_col] = p;
            if (m_row >= 2 && m_col >= 2) begin
                m_valid = 1'b1;
                for (int k = 0; k < 9; k++)
                    m_win.w[k] = img[m_row - 2 + k / 3][m_col - 2 + k % 3];
                m_win.last = (m_row == H - 1) && (m_col == W - 1);
            end else begin
                m_valid = 1'b0;
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end else if (wr) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send_pixel(input logic [N-1:0] p, input int v_pct, input int wr_pct);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            if (stall_req && m_valid) begin
                repeat (3) cycle(1'b1, p, 1'b0, acc);
                stall_req = 1'b0;
            end else begin
                cycle($urandom_range(99) < v_pct, p, $urandom_range(99) < wr_pct, acc);
            end
            tries++;
        end
        if (!acc) check("accept_timeout", acc, 1'b1);
    endtask

    task automatic send_frame(input int v_pct, input int wr_pct, input bit rand_pix);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pixel(rand_pix ? N'($urandom) : N'(r * W + c + 1), v_pct, wr_pct);
    endtask

    task automatic flush();
        logic acc;
        repeat (3) cycle(1'b0, '0, 1'b1, acc);
    endtask

    task automatic compare_golden(input string tag, input int nframes);
        int lasts;
        lasts = 0;
        check({tag, "_count"}, got_q.size(), 6 * nframes);
        for (int i = 0; i < got_q.size() && i < 6 * nframes; i++) begin
            check({tag, "_win"}, got_q[i].w, golden[i % 6].w);
            check({tag, "_last"}, got_q[i].last, golden[i % 6].last);
            if (got_q[i].last) lasts++;
        end
        check({tag, "_last_cnt"}, lasts, nframes);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0][N-1:0] first_exp;
        win_t g;

        // Golden windows of the canonical frame, straight from pixel = r*W+c+1.
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++) begin
                for (int k = 0; k < 9; k++)
                    g.w[k] = N'((r - 2 + k / 3) * W + (c - 2 + k % 3) + 1);
                g.last = (r == H - 1) && (c == W - 1);
                golden.push_back(g);
            end
        first_exp = {8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1};
        stall_req = 1'b0;

        // Reset state.
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_in    = '0;
        win_ready = 1'b1;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1 + 2: continuous frame, row wrap behaviour.
        got_q.delete();
        send_frame(100, 100, 1'b0);
        flush();
        compare_golden("s1", 1);
        if (got_q.size() >= 6) begin
            check("s1_first_window", got_q[0].w, first_exp);
            check("s1_last_win8", got_q[5].w[8], 8'd20);
            check("s1_last_win0", got_q[5].w[0], 8'd8);
            check("s1_last_flag", got_q[5].last, 1'b1);
            check("s2_after15_win8", got_q[2].w[8], 8'd15);
            check("s2_after15_win0", got_q[2].w[0], 8'd3);
            check("s2_after18_win0", got_q[3].w[0], 8'd6);
            check("s2_after18_win6", got_q[3].w[6], 8'd16);
        end

        // 3: backpressure for three cycles while a window is presented.
        got_q.delete();
        stall_req = 1'b1;
        send_frame(100, 100, 1'b0);
        flush();
        check("s3_stall_taken", stall_req, 1'b0);
        compare_golden("s3", 1);

        // 4: random pix_valid gaps.
        got_q.delete();
        send_frame(50, 100, 1'b0);
        flush();
        compare_golden("s4", 1);

        // 5: reset after 12 pixels, then a full frame.
        got_q.delete();
        for (int i = 0; i < 12; i++) send_pixel(N'(i + 1), 100, 100);
        pix_valid = 1'b0;
        rst       = 1'b1;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        send_frame(100, 100, 1'b0);
        flush();
        compare_golden("s5", 1);

        // 6: two frames back to back.
        got_q.delete();
        send_frame(100, 100, 1'b0);
        send_frame(100, 100, 1'b0);
        flush();
        compare_golden("s6", 2);

        // Random pixel data with random gaps and random downstream stalls.
        got_q.delete();
        send_frame(60, 60, 1'b1);
        flush();
        check("rand_count", got_q.size(), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
